// File: rtl/bfs_pkg.sv
// bfs_pkg: shared FSM state type and widths for the BFS frontier scheduler
package bfs_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE, COLLECT, EMIT, DONE} state_t;
   localparam int VADDR_W = 32;
   localparam int COUNT_W = 16;
endpackage

// File: rtl/bfs_fifo.sv
// bfs_fifo: first-word-fall-through FIFO holding the BFS frontier
module bfs_fifo import bfs_pkg::*; #(
   parameter int DATA_WIDTH = VADDR_W,
   parameter int DEPTH      = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  empty,
   output logic                  full
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0] count;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count == (AW+1)'(DEPTH);
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign head = mem[rd_ptr];
   always_ff @(posedge clk_in)
      if (do_push) mem[wr_ptr] <= push_data;
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
endmodule

// File: rtl/visited_bitmap.sv
// visited_bitmap: one flag per low-order address; clear_all beats set_en
module visited_bitmap #(
   parameter int VBITS = 10
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             clear_all,
   input  logic             set_en,
   input  logic [VBITS-1:0] set_idx,
   input  logic [VBITS-1:0] test_idx,
   output logic             test_out
);
   logic [2**VBITS-1:0] bits;
   assign test_out = bits[test_idx];
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) bits <= '0;
      else if (clear_all) bits <= '0;
      else if (set_en) bits[set_idx] <= 1'b1;
endmodule

// File: rtl/bfs_frontier_sched.sv
// bfs_frontier_sched: BFS controller around the graph fetch stage.
// Define BFS_FRONTIER_STATS_EN to enable the edges_seen/dup_drop counters.
module bfs_frontier_sched import bfs_pkg::*; #(
   parameter int DIM         = 2,
   parameter int QDEPTH      = 16,
   parameter int VBITS       = 10,
   parameter int IDLE_CYCLES = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 start_in,
   input  logic [VADDR_W-1:0]   root_addr_in,
   output logic                 busy_out,
   output logic                 done_out,
   output logic [COUNT_W-1:0]   visited_count_out,
   output logic                 overflow_out,
   output logic [VADDR_W-1:0]   fetch_addr_out,
   output logic                 fetch_valid_out,
   input  logic                 fetch_ready_in,
   input  logic [31:0]          pos_data_in,
   input  logic                 pos_valid_in,
   output logic                 pos_deq_out,
   input  logic [VADDR_W-1:0]   neigh_data_in,
   input  logic                 neigh_valid_in,
   output logic                 neigh_deq_out,
   output logic [DIM*32-1:0]    vec_out,
   output logic [VADDR_W-1:0]   vec_addr_out,
   output logic                 vec_valid_out,
   input  logic                 vec_ready_in,
   output logic [31:0]          edges_seen_out,
   output logic [31:0]          dup_drop_out
);
   localparam int CT_W = $clog2(DIM+1);
   localparam int ID_W = $clog2(IDLE_CYCLES+1);
   state_t state, state_nx;
   logic [CT_W-1:0] ct;
   logic [ID_W-1:0] idle;
   logic start_go, take_fetch, n_fresh, bm_hit, q_empty, q_full;
   logic [VADDR_W-1:0] q_head;
   assign start_go = state == IDLE && start_in;
   assign take_fetch = state == ISSUE && !q_empty && fetch_ready_in;
   assign pos_deq_out = state == COLLECT && pos_valid_in && ct < CT_W'(DIM);
   assign neigh_deq_out = state == COLLECT && neigh_valid_in;
   assign n_fresh = neigh_deq_out && !bm_hit && !q_full;
   assign busy_out = state == ISSUE || state == COLLECT || state == EMIT;
   assign done_out = state == DONE;
   assign vec_valid_out = state == EMIT;
   bfs_fifo #(.DATA_WIDTH(VADDR_W), .DEPTH(QDEPTH)) u_frontier (
      .clk_in(clk_in), .rst_in(rst_in),
      .push(start_go || n_fresh), .push_data(start_go ? root_addr_in : neigh_data_in),
      .pop(take_fetch), .head(q_head), .empty(q_empty), .full(q_full)
   );
   // The root is marked when it is popped: the bitmap clear on start would swallow a same-cycle set.
   visited_bitmap #(.VBITS(VBITS)) u_visited (
      .clk_in(clk_in), .rst_in(rst_in), .clear_all(start_go),
      .set_en(take_fetch || n_fresh),
      .set_idx(take_fetch ? q_head[VBITS-1:0] : neigh_data_in[VBITS-1:0]),
      .test_idx(neigh_data_in[VBITS-1:0]), .test_out(bm_hit)
   );
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start_in ? ISSUE : IDLE;
         ISSUE:   state_nx = q_empty ? DONE : (fetch_ready_in ? COLLECT : ISSUE);
         COLLECT: state_nx = (ct == CT_W'(DIM) && idle == ID_W'(IDLE_CYCLES)) ? EMIT : COLLECT;
         EMIT:    state_nx = vec_ready_in ? ISSUE : EMIT;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) begin
         state <= IDLE;
         ct <= '0;
         idle <= '0;
         fetch_addr_out <= '0;
         fetch_valid_out <= 1'b0;
         vec_out <= '0;
         vec_addr_out <= '0;
         visited_count_out <= '0;
         overflow_out <= 1'b0;
      end else begin
         state <= state_nx;
         fetch_valid_out <= take_fetch;
         if (take_fetch) begin
            fetch_addr_out <= q_head;
            vec_addr_out <= q_head;
            ct <= '0;
            idle <= '0;
         end
         if (pos_deq_out) ct <= ct + 1'b1;
         for (int i = 0; i < DIM; i++)
            if (pos_deq_out && ct == CT_W'(i)) vec_out[i*32 +: 32] <= pos_data_in;
         if (state == COLLECT)
            idle <= neigh_valid_in ? '0 : (idle == ID_W'(IDLE_CYCLES) ? idle : idle + 1'b1);
         if (start_go) visited_count_out <= '0;
         else if (state == EMIT && vec_ready_in && visited_count_out != '1)
            visited_count_out <= visited_count_out + 1'b1;
         if (start_go) overflow_out <= 1'b0;
         else if (neigh_deq_out && !bm_hit && q_full) overflow_out <= 1'b1;
      end
`ifdef BFS_FRONTIER_STATS_EN
   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) begin
         edges_seen_out <= '0;
         dup_drop_out <= '0;
      end else if (start_go) begin
         edges_seen_out <= '0;
         dup_drop_out <= '0;
      end else begin
         if (neigh_deq_out) edges_seen_out <= edges_seen_out + 1'b1;
         if (neigh_deq_out && bm_hit) dup_drop_out <= dup_drop_out + 1'b1;
      end
`else
   assign edges_seen_out = '0;
   assign dup_drop_out = '0;
`endif
endmodule

// File: tb/tb_bfs_frontier_sched.sv
// tb_bfs_frontier_sched: graph-memory model feeding the scheduler, BFS reference scoreboard
module tb_bfs_frontier_sched;
   localparam int DIM = 2, QDEPTH = 16, VBITS = 10, IDLE_CYCLES = 4;
   logic clk_in = 1'b0, rst_in = 1'b0, start_in = 1'b0;
   logic [31:0] root_addr_in = '0;
   logic busy_out, done_out, overflow_out, fetch_valid_out, pos_deq_out, neigh_deq_out, vec_valid_out;
   logic [15:0] visited_count_out;
   logic [31:0] fetch_addr_out, vec_addr_out, edges_seen_out, dup_drop_out;
   logic fetch_ready_in = 1'b1, pos_valid_in = 1'b0, neigh_valid_in = 1'b0, vec_ready_in = 1'b1;
   logic [31:0] pos_data_in = '0, neigh_data_in = '0;
   logic [63:0] vec_out;

   always #5 clk_in = ~clk_in;

   bfs_frontier_sched #(.DIM(DIM), .QDEPTH(QDEPTH), .VBITS(VBITS), .IDLE_CYCLES(IDLE_CYCLES)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .root_addr_in(root_addr_in),
      .busy_out(busy_out), .done_out(done_out), .visited_count_out(visited_count_out),
      .overflow_out(overflow_out), .fetch_addr_out(fetch_addr_out), .fetch_valid_out(fetch_valid_out),
      .fetch_ready_in(fetch_ready_in), .pos_data_in(pos_data_in), .pos_valid_in(pos_valid_in),
      .pos_deq_out(pos_deq_out), .neigh_data_in(neigh_data_in), .neigh_valid_in(neigh_valid_in),
      .neigh_deq_out(neigh_deq_out), .vec_out(vec_out), .vec_addr_out(vec_addr_out),
      .vec_valid_out(vec_valid_out), .vec_ready_in(vec_ready_in),
      .edges_seen_out(edges_seen_out), .dup_drop_out(dup_drop_out)
   );

   logic [31:0] pos_mem [1024][2];
   logic [31:0] nb_mem [1024][20];
   int nb_cnt [1024];
   logic [31:0] pos_q[$], nb_q[$], act_addr[$], fetch_log[$], exp_addr[$], exp_fetch[$];
   logic [63:0] act_vec[$], exp_vec[$];
   int pass_cnt = 0, total = 0;
   int e_edges, e_dups, e_count;
   logic e_ovf;
   logic pd_s = 1'b0, nd_s = 1'b0, fv_s = 1'b0;
   logic [31:0] fa_s = '0, drv_tmp;

   // Handshakes are captured before the edge updates the DUT, then replayed on the memory model at negedge.
   always @(posedge clk_in) begin
      pd_s <= pos_deq_out;
      nd_s <= neigh_deq_out;
      fv_s <= fetch_valid_out;
      fa_s <= fetch_addr_out;
      if (vec_valid_out && vec_ready_in) begin
         act_addr.push_back(vec_addr_out);
         act_vec.push_back(vec_out);
      end
      if (fetch_valid_out) fetch_log.push_back(fetch_addr_out);
   end

   always @(negedge clk_in) begin
      if (pd_s && pos_q.size() > 0) drv_tmp = pos_q.pop_front();
      if (nd_s && nb_q.size() > 0) drv_tmp = nb_q.pop_front();
      if (fv_s) begin
         for (int i = 0; i < DIM; i++) pos_q.push_back(pos_mem[fa_s[9:0]][i]);
         for (int i = 0; i < nb_cnt[fa_s[9:0]]; i++) nb_q.push_back(nb_mem[fa_s[9:0]][i]);
      end
      pos_valid_in = pos_q.size() > 0;
      pos_data_in = '0;
      if (pos_valid_in) pos_data_in = pos_q[0];
      neigh_valid_in = nb_q.size() > 0;
      neigh_data_in = '0;
      if (neigh_valid_in) neigh_data_in = nb_q[0];
   end

   task automatic clear_graph();
      for (int i = 0; i < 1024; i++) begin
         nb_cnt[i] = 0;
         pos_mem[i][0] = '0;
         pos_mem[i][1] = '0;
      end
      act_addr.delete(); act_vec.delete(); fetch_log.delete();
   endtask

   task automatic add_vertex(input int a, input logic [31:0] p0, input logic [31:0] p1);
      pos_mem[a][0] = p0;
      pos_mem[a][1] = p1;
   endtask

   task automatic add_edge(input int a, input int n);
      nb_mem[a][nb_cnt[a]] = n;
      nb_cnt[a]++;
   endtask

   // Reference breadth-first traversal with a bounded queue, mark-at-push semantics.
   task automatic model_bfs(input logic [31:0] root);
      logic [31:0] q[$];
      logic [31:0] a, n;
      bit vis [1024];
      int edges, dups;
      for (int i = 0; i < 1024; i++) vis[i] = 1'b0;
      exp_addr.delete(); exp_vec.delete(); exp_fetch.delete();
      edges = 0; dups = 0; e_ovf = 1'b0;
      q.push_back(root);
      vis[root[9:0]] = 1'b1;
      while (q.size() > 0) begin
         a = q.pop_front();
         exp_addr.push_back(a);
         exp_fetch.push_back(a);
         exp_vec.push_back({pos_mem[a[9:0]][1], pos_mem[a[9:0]][0]});
         for (int i = 0; i < nb_cnt[a[9:0]]; i++) begin
            n = nb_mem[a[9:0]][i];
            edges++;
            if (vis[n[9:0]]) dups++;
            else if (q.size() < QDEPTH) begin
               q.push_back(n);
               vis[n[9:0]] = 1'b1;
            end else e_ovf = 1'b1;
         end
      end
      e_count = exp_addr.size();
`ifdef BFS_FRONTIER_STATS_EN
      e_edges = edges; e_dups = dups;
`else
      e_edges = 0; e_dups = 0;
`endif
   endtask

   task automatic start_run(input logic [31:0] root);
      model_bfs(root);
      @(negedge clk_in);
      root_addr_in = root;
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         if (done_out) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      repeat (3) @(negedge clk_in);
      total++;
      if ({busy_out, done_out, overflow_out, fetch_valid_out, pos_deq_out, neigh_deq_out, vec_valid_out} !== 7'b0)
         $display("FAIL reset_flags got %b want 0", {busy_out, done_out, overflow_out, fetch_valid_out, pos_deq_out, neigh_deq_out, vec_valid_out});
      else pass_cnt++;
      total++;
      if ({visited_count_out, fetch_addr_out, vec_out, vec_addr_out, edges_seen_out, dup_drop_out} !== '0)
         $display("FAIL reset_data count=%0d faddr=%h vec=%h vaddr=%h edges=%0d dups=%0d want all 0",
                  visited_count_out, fetch_addr_out, vec_out, vec_addr_out, edges_seen_out, dup_drop_out);
      else pass_cnt++;
      rst_in = 1'b1;
      @(negedge clk_in);
   endtask

   task automatic test_chain();
      int lat;
      bit ok;
      clear_graph();
      add_vertex(10, 5, 7); add_edge(10, 20);
      add_vertex(20, 1, 2); add_edge(20, 10);
      model_bfs(10);
      @(negedge clk_in);
      root_addr_in = 10;
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      lat = 1;
      total++;
      if (busy_out !== 1'b1) $display("FAIL chain_busy got %b want 1", busy_out); else pass_cnt++;
      while (!fetch_valid_out && lat < 20) begin
         @(negedge clk_in);
         lat++;
      end
      total++;
      if (lat != 2) $display("FAIL start_latency got %0d want 2", lat); else pass_cnt++;
      wait_done(500, ok);
      total++;
      if (!ok) $display("FAIL chain_done got timeout want done_out"); else pass_cnt++;
      total++;
      if (busy_out !== 1'b0 || visited_count_out !== 16'(e_count) || overflow_out !== e_ovf)
         $display("FAIL chain_status busy=%b count=%0d ovf=%b want 0/%0d/%b", busy_out, visited_count_out, overflow_out, e_count, e_ovf);
      else pass_cnt++;
      total++;
      if (edges_seen_out !== 32'(e_edges) || dup_drop_out !== 32'(e_dups))
         $display("FAIL chain_stats edges=%0d dups=%0d want %0d/%0d", edges_seen_out, dup_drop_out, e_edges, e_dups);
      else pass_cnt++;
      total++;
      if (act_addr.size() != exp_addr.size()) $display("FAIL chain_nvec got %0d want %0d", act_addr.size(), exp_addr.size());
      else pass_cnt++;
      while (exp_addr.size() > 0 && act_addr.size() > 0) begin
         logic [31:0] ea = exp_addr.pop_front(), aa = act_addr.pop_front();
         logic [63:0] ev = exp_vec.pop_front(), av = act_vec.pop_front();
         total++;
         if (aa !== ea || av !== ev) $display("FAIL chain_vec got %0d:%h want %0d:%h", aa, av, ea, ev); else pass_cnt++;
      end
   endtask

   task automatic test_star();
      bit ok;
      clear_graph();
      add_vertex(10, 100, 101);
      add_edge(10, 20); add_edge(10, 30); add_edge(10, 40);
      add_vertex(20, 200, 201); add_vertex(30, 300, 301); add_vertex(40, 400, 401);
      start_run(10);
      wait_done(500, ok);
      total++;
      if (!ok || visited_count_out !== 16'(e_count)) $display("FAIL star_count got %0d done=%b want %0d", visited_count_out, ok, e_count);
      else pass_cnt++;
      total++;
      if (fetch_log.size() != exp_fetch.size()) $display("FAIL star_nfetch got %0d want %0d", fetch_log.size(), exp_fetch.size());
      else pass_cnt++;
      while (exp_fetch.size() > 0 && fetch_log.size() > 0) begin
         logic [31:0] ef = exp_fetch.pop_front(), af = fetch_log.pop_front();
         total++;
         if (af !== ef) $display("FAIL star_fetch got %0d want %0d", af, ef); else pass_cnt++;
      end
      while (exp_addr.size() > 0 && act_addr.size() > 0) begin
         logic [31:0] ea = exp_addr.pop_front(), aa = act_addr.pop_front();
         logic [63:0] ev = exp_vec.pop_front(), av = act_vec.pop_front();
         total++;
         if (aa !== ea || av !== ev) $display("FAIL star_vec got %0d:%h want %0d:%h", aa, av, ea, ev); else pass_cnt++;
      end
   endtask

   task automatic test_overflow();
      bit ok;
      clear_graph();
      add_vertex(200, 7, 8);
      for (int i = 1; i <= QDEPTH + 1; i++) begin
         add_edge(200, 200 + i);
         add_vertex(200 + i, 32'(i), 32'(i + 1000));
      end
      start_run(200);
      wait_done(3000, ok);
      total++;
      if (!ok || visited_count_out !== 16'(e_count) || overflow_out !== 1'b1 || e_count != QDEPTH + 1)
         $display("FAIL overflow_status done=%b count=%0d ovf=%b want count %0d ovf 1", ok, visited_count_out, overflow_out, QDEPTH + 1);
      else pass_cnt++;
      total++;
      if (edges_seen_out !== 32'(e_edges) || dup_drop_out !== 32'(e_dups))
         $display("FAIL overflow_stats edges=%0d dups=%0d want %0d/%0d", edges_seen_out, dup_drop_out, e_edges, e_dups);
      else pass_cnt++;
      while (exp_addr.size() > 0 && act_addr.size() > 0) begin
         logic [31:0] ea = exp_addr.pop_front(), aa = act_addr.pop_front();
         logic [63:0] ev = exp_vec.pop_front(), av = act_vec.pop_front();
         total++;
         if (aa !== ea || av !== ev) $display("FAIL overflow_vec got %0d:%h want %0d:%h", aa, av, ea, ev); else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int n;
      logic [63:0] v;
      logic [31:0] a;
      clear_graph();
      add_vertex(10, 5, 7); add_edge(10, 20);
      add_vertex(20, 1, 2); add_edge(20, 10);
      vec_ready_in = 1'b0;
      start_run(10);
      n = 0;
      while (!vec_valid_out && n < 200) begin
         @(negedge clk_in);
         n++;
      end
      total++;
      if (!vec_valid_out) $display("FAIL hold_valid got timeout want vec_valid_out"); else pass_cnt++;
      v = vec_out;
      a = vec_addr_out;
      total++;
      if (v !== exp_vec[0] || a !== exp_addr[0]) $display("FAIL hold_first got %0d:%h want %0d:%h", a, v, exp_addr[0], exp_vec[0]);
      else pass_cnt++;
      repeat (10) begin
         @(negedge clk_in);
         total++;
         if (vec_valid_out !== 1'b1 || vec_out !== v || vec_addr_out !== a || fetch_valid_out !== 1'b0)
            $display("FAIL hold_stable got valid=%b %0d:%h fetch=%b want 1 %0d:%h 0", vec_valid_out, vec_addr_out, vec_out, fetch_valid_out, a, v);
         else pass_cnt++;
      end
      vec_ready_in = 1'b1;
      wait_done(500, ok);
      total++;
      if (!ok || visited_count_out !== 16'(e_count) || act_addr.size() != exp_addr.size())
         $display("FAIL hold_finish done=%b count=%0d nvec=%0d want %0d", ok, visited_count_out, act_addr.size(), e_count);
      else pass_cnt++;
   endtask

   task automatic test_self_loop();
      bit ok;
      clear_graph();
      add_vertex(10, 9, 9); add_edge(10, 10);
      start_run(10);
      wait_done(500, ok);
      total++;
      if (!ok || visited_count_out !== 16'd1 || overflow_out !== 1'b0)
         $display("FAIL self_loop done=%b count=%0d ovf=%b want 1/0", ok, visited_count_out, overflow_out);
      else pass_cnt++;
      total++;
      if (edges_seen_out !== 32'(e_edges) || dup_drop_out !== 32'(e_dups))
         $display("FAIL self_loop_stats edges=%0d dups=%0d want %0d/%0d", edges_seen_out, dup_drop_out, e_edges, e_dups);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      bit ok, saw_done;
      int n;
      clear_graph();
      add_vertex(10, 5, 7); add_edge(10, 20);
      add_vertex(20, 1, 2); add_edge(20, 10);
      start_run(10);
      n = 0;
      while (!fetch_valid_out && n < 50) begin
         @(negedge clk_in);
         n++;
      end
      repeat (2) @(negedge clk_in);
      #2 rst_in = 1'b0;
      #1;
      total++;
      if ({busy_out, done_out, fetch_valid_out, pos_deq_out, neigh_deq_out, vec_valid_out, overflow_out} !== 7'b0 ||
          {visited_count_out, fetch_addr_out, vec_out, vec_addr_out, edges_seen_out, dup_drop_out} !== '0)
         $display("FAIL reset_mid flags=%b count=%0d faddr=%h vec=%h want all 0",
                  {busy_out, done_out, fetch_valid_out, pos_deq_out, neigh_deq_out, vec_valid_out, overflow_out},
                  visited_count_out, fetch_addr_out, vec_out);
      else pass_cnt++;
      pos_q.delete(); nb_q.delete();
      act_addr.delete(); act_vec.delete(); fetch_log.delete();
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge clk_in);
         saw_done |= done_out;
      end
      rst_in = 1'b1;
      repeat (3) begin
         @(negedge clk_in);
         saw_done |= done_out | busy_out;
      end
      total++;
      if (saw_done) $display("FAIL reset_mid_quiet got done/busy activity want none"); else pass_cnt++;
      start_run(10);
      wait_done(500, ok);
      total++;
      if (!ok || visited_count_out !== 16'(e_count) || act_addr.size() != exp_addr.size())
         $display("FAIL rerun_status done=%b count=%0d nvec=%0d want %0d", ok, visited_count_out, act_addr.size(), e_count);
      else pass_cnt++;
      while (exp_addr.size() > 0 && act_addr.size() > 0) begin
         logic [31:0] ea = exp_addr.pop_front(), aa = act_addr.pop_front();
         logic [63:0] ev = exp_vec.pop_front(), av = act_vec.pop_front();
         total++;
         if (aa !== ea || av !== ev) $display("FAIL rerun_vec got %0d:%h want %0d:%h", aa, av, ea, ev); else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_chain();
      test_star();
      test_overflow();
      test_backpressure();
      test_self_loop();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
